// File: rtl/dn_timer_nb_pkg.sv
// Shared types and constants for the dn_timer_nb down-timer.
// The auto-reload build is selected with DN_TIMER_RELOAD_EN.
package dn_timer_nb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int CNT_RST = 0;

endpackage

// File: rtl/cntr_dn_ld_nb.sv
// n-bit loadable down counter with sync clear and zero flag.
// Priority: clr > ld > dec; decrement saturates at zero.
module cntr_dn_ld_nb
  import dn_timer_nb_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic         dec,
  input  logic [n-1:0] d,
  output logic [n-1:0] q,
  output logic         zero
);

  logic [n-1:0] q_q;
  logic [n-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (dec && (q_q != '0)) begin
      q_d = q_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= n'(CNT_RST);
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign zero = (q_q == '0);

endmodule

// File: rtl/dn_timer_nb.sv
// Two-state down timer with done pulse at terminal count.
// DN_TIMER_RELOAD_EN: reload from the period register and keep running.
module dn_timer_nb
  import dn_timer_nb_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic         stop,
  input  logic         en,
  input  logic [n-1:0] D,
  output logic [n-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         rco
);

  state_e       state_q;
  state_e       state_d;
  logic         done_q;
  logic         done_d;
  logic         ld;
  logic         dec;
  logic [n-1:0] ld_val;
  logic         zero;

`ifdef DN_TIMER_RELOAD_EN
  logic [n-1:0] period_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      period_q <= '0;
    end else if (!stop && start) begin
      period_q <= D;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    ld      = 1'b0;
    dec     = 1'b0;
    ld_val  = D;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
      ld      = 1'b1;
    end else if ((state_q == RUN) && en) begin
      if (!zero) begin
        dec = 1'b1;
      end else begin
        done_d = 1'b1;
`ifdef DN_TIMER_RELOAD_EN
        ld     = 1'b1;
        ld_val = period_q;
`else
        state_d = IDLE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  cntr_dn_ld_nb #(
    .n(n)
  ) u_cntr (
    .clk (clk),
    .clr (clr),
    .ld  (ld),
    .dec (dec),
    .d   (ld_val),
    .q   (count),
    .zero(zero)
  );

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign rco  = zero;

endmodule

// File: doc/dn_timer_nb.md
DN_TIMER_NB -- requirements
Module: dn_timer_nb

Interface
REQ-001 Parameter: n, default 8, width of period and count.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: clr  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  load period D and begin counting.
REQ-005 Port: stop  input  1  abort run, return to idle.
REQ-006 Port: en  input  1  count enable while running; low = hold.
REQ-007 Port: D  input  n  period value, sampled only on accepted start.
REQ-008 Port: count  output  n  registered current count.
REQ-009 Port: busy  output  1  high while state is RUN.
REQ-010 Port: done  output  1  registered one-cycle pulse at terminal count.
REQ-011 Port: rco  output  1  combinational, high when count == 0.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-013 Per-edge priority SHALL be clr > stop > start > count.
REQ-014 IDLE + start: count <= D, period register <= D, state -> RUN.
REQ-015 IDLE without start: count, period register and state hold; done = 0.
REQ-016 RUN + en + count != 0: count <= count - 1, no wrap.
REQ-017 RUN + en + count == 0: done = 1 for the next cycle only; one-shot: state -> IDLE, count stays 0.
REQ-018 RUN + !en: count holds; done = 0; no terminal event while en is low.
REQ-019 Latency: start accepted at edge k, en held high -> done high during cycle after edge k+D+1, i.e. D+1 enabled cycles per period.
REQ-020 D == 0 on start: no special case; done pulses after the first enabled RUN cycle.
REQ-021 RUN + start (no stop): restart, count <= D, period register <= D, no done for the aborted period.
REQ-022 stop in RUN: state -> IDLE, count holds current value, no done; stop in IDLE has no effect.
REQ-023 start and stop in the same cycle: stop wins, start is discarded.
REQ-024 busy SHALL be decoded from state only and be high from the edge accepting start until the edge leaving RUN.
REQ-025 done SHALL never be high for two consecutive cycles in one-shot mode.

Reset
REQ-026 On clr at a rising edge: count = 0, period register = 0, state = IDLE, done = 0; hence busy = 0, rco = 1.
REQ-027 clr mid-run SHALL abort immediately with no done pulse, overriding start, stop and en.

Configuration
REQ-028 Macro DN_TIMER_RELOAD_EN SHALL select auto-reload.
REQ-029 Defined: at the terminal event (REQ-017) count <= period register, state stays RUN, and done pulses once per period; back-to-back done pulses SHALL occur when period register == 0 and en is high.
REQ-030 Undefined: one-shot behaviour per REQ-017; no reload logic or period register readback is synthesised beyond the start value.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, RUN) and the reset constant for count.
REQ-032 One sub-module, cntr_dn_ld_nb (n-bit synchronous-clear, loadable down counter with zero flag), SHALL implement the count datapath; the FSM, period register and done register live in dn_timer_nb.

Verification
REQ-033 n=8, clr, then start with D=3, en=1 -> count 3,2,1,0; done high exactly one cycle after count reaches 0 on the next edge; busy low after.
REQ-034 D=5, start, en toggled 1,0,1,0,... -> count decrements only on en=1 cycles; done after 6 enabled cycles.
REQ-035 D=10, start, stop after count=7 -> state IDLE, count holds 7, done never asserted, busy low.
REQ-036 Running with count=4, clr asserted with start=1 -> count=0, busy=0, done=0, rco=1 next cycle.
REQ-037 D=0, start, en=1 -> done one cycle after the first RUN edge; with DN_TIMER_RELOAD_EN, done high every cycle until stop.
REQ-038 DN_TIMER_RELOAD_EN defined, D=2, en=1 for 12 cycles -> count 2,1,0,2,1,0,...; done pulses every 3 cycles; busy stays high.
